// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command sender: inhibit, request-to-send, 11 device-clocked bits, ACK check.
// Lines filtered 2FF+4 samples (~7 clk lag); start accepted only while idle, never queued.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 12000,
    parameter int SETUP_CYC   = 200,
    parameter int TIMEOUT_CYC = 1500000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] din,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int MAX_A = (INHIBIT_CYC > SETUP_CYC) ? INHIBIT_CYC : SETUP_CYC;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_SETUP, S_RELEASE, S_BITS, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    frame_q, frame_d;
    logic          bit_q, bit_d;
    logic [3:0]    idx_q, idx_d;
    logic          ack_q, ack_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic [3:0]    clk_hist_q, dat_hist_q;
    logic          clk_filt_q, dat_filt_q, clk_prev_q;
    logic          fall;
    logic          timed;
    logic          tmo;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_hist_q <= 4'hF;
            dat_hist_q <= 4'hF;
            clk_filt_q <= 1'b1;
            dat_filt_q <= 1'b1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_data_in};
            clk_hist_q <= {clk_hist_q[2:0], clk_sync_q[1]};
            dat_hist_q <= {dat_hist_q[2:0], dat_sync_q[1]};
            if (clk_hist_q == 4'hF) clk_filt_q <= 1'b1;
            else if (clk_hist_q == 4'h0) clk_filt_q <= 1'b0;
            if (dat_hist_q == 4'hF) dat_filt_q <= 1'b1;
            else if (dat_hist_q == 4'h0) dat_filt_q <= 1'b0;
            clk_prev_q <= clk_filt_q;
        end
    end

    assign fall  = clk_prev_q & ~clk_filt_q;
    assign timed = (state_q == S_RELEASE) || (state_q == S_BITS) ||
                   (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    // A device edge in the same cycle as the limit wins over the timeout.
    assign tmo   = timed && !fall && (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        frame_d = frame_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        ack_d   = ack_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    frame_d = {~^din, din};
                    bit_d   = 1'b0;
                    idx_d   = 4'd0;
                    ack_d   = 1'b0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: if (cnt_q == INH_LAST) state_d = S_SETUP;
            S_SETUP:   if (cnt_q == SET_LAST) state_d = S_RELEASE;
            S_RELEASE, S_BITS: begin
                if (fall) begin
                    // Ones shifted in behind the parity bit become the stop bit.
                    bit_d   = frame_q[0];
                    frame_d = {1'b1, frame_q[8:1]};
                    idx_d   = idx_q + 4'd1;
                    state_d = (idx_q == 4'd9) ? S_ACK : S_BITS;
                end
            end
            S_ACK: begin
                if (fall) begin
                    ack_d   = ~dat_filt_q;
                    err_d   = dat_filt_q;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_filt_q && dat_filt_q) begin
                    done_d  = ack_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (tmo) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            // A NACK already reported its err; do not pulse a second one.
            err_d   = (state_q == S_WAIT_IDLE) ? ack_q : 1'b1;
        end
        if ((state_d != state_q) || (timed && fall)) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            frame_q <= 9'h1FF;
            bit_q   <= 1'b1;
            idx_q   <= 4'd0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_SETUP);
    assign ps2_data_oe = ((state_q == S_SETUP) || (state_q == S_RELEASE) ||
                          (state_q == S_BITS)) && ~bit_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
endmodule
